// File: rtl/conv_pkg.sv
// Shared definitions for the conv/pool/flatten datapath: scratch bank
// selects, pixel format and the default memory geometry.
package conv_pkg;

    localparam int unsigned DATA_WIDTH = 20;
    localparam int unsigned INT_WIDTH  = 4;
    localparam int unsigned FRAC_WIDTH = 16;
    localparam int unsigned ADDR_WIDTH = 12;

    // Scratch memory bank select codes.
    typedef enum logic [2:0] {
        NONE   = 3'b000,
        L0     = 3'b001,
        L1_CH0 = 3'b011,
        L1_CH1 = 3'b100,
        L2     = 3'b101
    } mem_sel_e;

    // Signed fixed-point pixel, 4 integer + 16 fraction bits.
    typedef struct packed {
        logic signed [INT_WIDTH-1:0] int_part;
        logic [FRAC_WIDTH-1:0]       frac_part;
    } pixel_t;

    // Layer-1 bank holding the given pooled channel.
    function automatic mem_sel_e l1_bank_sel(input logic ch);
        return ch ? L1_CH1 : L1_CH0;
    endfunction

endpackage

// File: rtl/flatten_stage_if.sv
// Control handshake plus the shared scratch memory port used by the
// flatten stage. master = the stage, slave = the memory/controller side.
interface flatten_stage_if #(
    parameter int unsigned DATA_WIDTH = conv_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = conv_pkg::ADDR_WIDTH
);

    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  crd;
    logic [ADDR_WIDTH-1:0] caddr_rd;
    logic [DATA_WIDTH-1:0] cdata_rd;
    logic                  cwr;
    logic [ADDR_WIDTH-1:0] caddr_wr;
    logic [DATA_WIDTH-1:0] cdata_wr;
    logic [2:0]            csel;

    modport master (
        input  start,
        input  cdata_rd,
        output busy,
        output done,
        output crd,
        output caddr_rd,
        output cwr,
        output caddr_wr,
        output cdata_wr,
        output csel
    );

    modport slave (
        output start,
        output cdata_rd,
        input  busy,
        input  done,
        input  crd,
        input  caddr_rd,
        input  cwr,
        input  caddr_wr,
        input  cdata_wr,
        input  csel
    );

endinterface

// File: rtl/flatten_addr_gen.sv
// Channel/index counters for the flatten stage. Channel runs fastest; the
// L2 address interleaves channels (idx*NUM_CH + ch).
module flatten_addr_gen #(
    parameter int unsigned NUM_CH     = 1,
    parameter int unsigned MAP_SIZE   = 1024,
    parameter int unsigned ADDR_WIDTH = conv_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output conv_pkg::mem_sel_e    rd_sel,
    output logic                  last
);
    import conv_pkg::*;

    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  ch_q, ch_d;

    // Next counter values: clear wins over step; channel wraps into index.
    always_comb begin
        idx_d = idx_q;
        ch_d  = ch_q;
        if (clear) begin
            idx_d = '0;
            ch_d  = 1'b0;
        end else if (step) begin
            if ((NUM_CH == 2) && !ch_q) begin
                ch_d = 1'b1;
            end else begin
                ch_d  = 1'b0;
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
            ch_q  <= 1'b0;
        end else begin
            idx_q <= idx_d;
            ch_q  <= ch_d;
        end
    end

    // Address, bank and end-of-map decode from the current counters.
    always_comb begin
        rd_addr = idx_q;
        wr_addr = (NUM_CH == 2) ? {idx_q[ADDR_WIDTH-2:0], ch_q} : idx_q;
        rd_sel  = l1_bank_sel(ch_q);
        last    = (idx_q == ADDR_WIDTH'(MAP_SIZE - 1)) && (ch_q == 1'(NUM_CH - 1));
    end

endmodule

// File: rtl/flatten_stage.sv
// Flatten stage: copies the pooled layer-1 map(s) into the layer-2 bank as
// one interleaved vector, 3 cycles per element (read, capture, write).
// Optional build macro FLATTEN_CHECKSUM_EN adds a running sign-extended sum
// of all written words on the checksum port.
module flatten_stage #(
    parameter int unsigned NUM_CH     = 1,
    parameter int unsigned MAP_SIZE   = 1024,
    parameter int unsigned DATA_WIDTH = conv_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = conv_pkg::ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
`ifdef FLATTEN_CHECKSUM_EN
    output logic [DATA_WIDTH+11:0] checksum,
`endif
    flatten_stage_if.master        bus
);
    import conv_pkg::*;

    if ((NUM_CH != 1) && (NUM_CH != 2)) begin : g_bad_num_ch
        $error("flatten_stage: NUM_CH must be 1 or 2");
    end
    if ((MAP_SIZE * NUM_CH) > (32'd1 << ADDR_WIDTH)) begin : g_bad_addr_width
        $error("flatten_stage: MAP_SIZE*NUM_CH does not fit in ADDR_WIDTH");
    end

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StCap,
        StWr,
        StFin
    } state_e;

    state_e                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  crd_q, crd_d;
    logic                  cwr_q, cwr_d;
    mem_sel_e              csel_q, csel_d;
    logic [ADDR_WIDTH-1:0] caddr_rd_q, caddr_rd_d;
    logic [ADDR_WIDTH-1:0] caddr_wr_q, caddr_wr_d;
    // Doubles as the captured read word (data_r): loaded at the end of CAP.
    logic [DATA_WIDTH-1:0] cdata_wr_q, cdata_wr_d;
    logic                  last_q, last_d;
`ifdef FLATTEN_CHECKSUM_EN
    logic [DATA_WIDTH+11:0] checksum_q, checksum_d;
`endif

    logic                  ag_clear;
    logic                  ag_step;
    logic [ADDR_WIDTH-1:0] ag_rd_addr;
    logic [ADDR_WIDTH-1:0] ag_wr_addr;
    mem_sel_e              ag_rd_sel;
    logic                  ag_last;

    flatten_addr_gen #(
        .NUM_CH     (NUM_CH),
        .MAP_SIZE   (MAP_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (ag_clear),
        .step    (ag_step),
        .rd_addr (ag_rd_addr),
        .wr_addr (ag_wr_addr),
        .rd_sel  (ag_rd_sel),
        .last    (ag_last)
    );

    // Next state and next registered outputs; outputs are decoded for the
    // state being entered so they are valid for the whole of that state.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        crd_d      = 1'b0;
        cwr_d      = 1'b0;
        csel_d     = NONE;
        caddr_rd_d = caddr_rd_q;
        caddr_wr_d = caddr_wr_q;
        cdata_wr_d = cdata_wr_q;
        last_d     = last_q;
        ag_clear   = 1'b0;
        ag_step    = 1'b0;
`ifdef FLATTEN_CHECKSUM_EN
        checksum_d = checksum_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Counters sit at element 0 while idle.
                if (bus.start) begin
                    state_d    = StRd;
                    busy_d     = 1'b1;
                    crd_d      = 1'b1;
                    csel_d     = ag_rd_sel;
                    caddr_rd_d = ag_rd_addr;
`ifdef FLATTEN_CHECKSUM_EN
                    checksum_d = '0;
`endif
                end
            end
            StRd: begin
                state_d = StCap;
            end
            StCap: begin
                state_d    = StWr;
                cwr_d      = 1'b1;
                csel_d     = L2;
                caddr_wr_d = ag_wr_addr;
                cdata_wr_d = bus.cdata_rd;
                last_d     = ag_last;
                // Advance now so the next read address is ready when WR ends.
                ag_step    = 1'b1;
`ifdef FLATTEN_CHECKSUM_EN
                checksum_d = checksum_q + {{12{bus.cdata_rd[DATA_WIDTH-1]}}, bus.cdata_rd};
`endif
            end
            StWr: begin
                if (last_q) begin
                    state_d = StFin;
                end else begin
                    state_d    = StRd;
                    crd_d      = 1'b1;
                    csel_d     = ag_rd_sel;
                    caddr_rd_d = ag_rd_addr;
                end
            end
            StFin: begin
                state_d  = StIdle;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                ag_clear = 1'b1;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; synchronous reset returns everything to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crd_q      <= 1'b0;
            cwr_q      <= 1'b0;
            csel_q     <= NONE;
            caddr_rd_q <= '0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
            last_q     <= 1'b0;
`ifdef FLATTEN_CHECKSUM_EN
            checksum_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            crd_q      <= crd_d;
            cwr_q      <= cwr_d;
            csel_q     <= csel_d;
            caddr_rd_q <= caddr_rd_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
            last_q     <= last_d;
`ifdef FLATTEN_CHECKSUM_EN
            checksum_q <= checksum_d;
`endif
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.crd      = crd_q;
    assign bus.cwr      = cwr_q;
    assign bus.csel     = csel_q;
    assign bus.caddr_rd = caddr_rd_q;
    assign bus.caddr_wr = caddr_wr_q;
    assign bus.cdata_wr = cdata_wr_q;
`ifdef FLATTEN_CHECKSUM_EN
    assign checksum     = checksum_q;
`endif

endmodule
